// File: rtl/framebuffer_scanout_pkg.sv
// Shared constants and types for the framebuffer scanout block: link header codes and the
// write-scheduler state encoding.
package framebuffer_scanout_pkg;

    localparam logic [3:0] PIO_RAM_EMU_HEADER_SEND_READ_ADDR  = 4'd1;
    localparam logic [3:0] PIO_RAM_EMU_HEADER_SEND_WRITE_ADDR = 4'd2;
    localparam logic [3:0] PIO_RAM_EMU_HEADER_SEND_WRITE_DATA = 4'd3;

    typedef enum logic [1:0] {
        WIdle,
        WAddr,
        WData
    } wstate_e;

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Message link between the scanout block and the PIO RAM emulator transmitter/receiver.
interface framebuffer_scanout_if;

    logic        tx_valid;
    logic [3:0]  tx_header;
    logic [15:0] tx_data;
    logic        tx_accepted;
    logic        rx_valid;
    logic [15:0] rx_data;

    modport master (
        output tx_valid, tx_header, tx_data,
        input  tx_accepted, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_header, tx_data,
        output tx_accepted, rx_valid, rx_data
    );

endinterface

// File: rtl/framebuffer_scanout_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; a pop in the same cycle frees room for a push when full.
module framebuffer_scanout_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        if (do_pop) begin
            rd_d = rd_q + PtrW'(1);
        end
        if (do_push) begin
            wr_d = wr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Raster scanout and write scheduler: read requests ahead of the beam in a fixed slot, queued
// writes as address/data pairs in the remaining slots, returned words unpacked into pixels.
module framebuffer_scanout
    import framebuffer_scanout_pkg::*;
#(
    parameter int X_BITS                = 12,
    parameter int Y_BITS                = 10,
    parameter int VY_BITS               = 9,
    parameter int LOG2_CYCLES_PER_PIXEL = 2,
    parameter int LOG2_PIXELS_PER_WORD  = 3,
    parameter int READ_HEAD_START       = 48,
    parameter int WQ_DEPTH              = 4,
    localparam int PIXEL_BITS           = 16 >> LOG2_PIXELS_PER_WORD
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [X_BITS-1:0] x_i,
    input  logic signed [Y_BITS-1:0] y_i,
    input  logic                     active_i,
    input  logic                     wr_valid_i,
    input  logic [15:0]              wr_addr_i,
    input  logic [15:0]              wr_data_i,
    output logic                     wr_ready_o,
    framebuffer_scanout_if.master    link_io,
    output logic [PIXEL_BITS-1:0]    pixel_o,
    output logic [1:0]               err_flags_o
);

    localparam int LOG2_CYCLES_PER_READ = LOG2_CYCLES_PER_PIXEL + LOG2_PIXELS_PER_WORD;
    localparam int XF_BITS              = 16 - VY_BITS;
    localparam int WQ_CNT_BITS          = $clog2(WQ_DEPTH) + 1;

    logic                   run_q;
    logic [X_BITS-1:0]      early_x;
    logic                   read_slot, write_take;
    logic [XF_BITS-1:0]     x_word;
    logic [15:0]            read_addr;
    logic                   wq_push, wq_pop, wq_empty, wq_full;
    logic [31:0]            wq_head;
    logic [WQ_CNT_BITS-1:0] wq_count;
    logic                   tag_push, tag_head, tag_empty, tag_full;
    logic [1:0]             tag_count;
    wstate_e                state_q, state_d;
    logic [31:0]            buf_q, buf_d;
    logic [1:0]             err_q, err_d;
    logic [PIXEL_BITS-1:0]  pixel_q, pixel_d;
    logic [LOG2_PIXELS_PER_WORD:0] field_idx;
    logic [4:0]             bit_lo;
    logic                   unused_bits;

    // run_q holds everything off for the first cycle after reset
    assign early_x    = $unsigned(x_i) + X_BITS'(READ_HEAD_START);
    assign read_slot  = run_q && (early_x[LOG2_CYCLES_PER_READ-1:0] == '0);
    assign write_take = !read_slot && link_io.tx_accepted;
    assign x_word     = early_x[LOG2_CYCLES_PER_PIXEL +: XF_BITS] >> LOG2_PIXELS_PER_WORD;
    assign read_addr  = {y_i[VY_BITS-1:0], x_word};

    assign wr_ready_o = run_q && !wq_full;
    assign wq_push    = wr_valid_i && wr_ready_o;
    assign tag_push   = read_slot && link_io.tx_accepted;

    framebuffer_scanout_sync_fifo #(
        .WIDTH (32),
        .DEPTH (WQ_DEPTH)
    ) u_write_q (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (wq_push),
        .data_i  ({wr_addr_i, wr_data_i}),
        .pop_i   (wq_pop),
        .data_o  (wq_head),
        .empty_o (wq_empty),
        .full_o  (wq_full),
        .count_o (wq_count)
    );

    framebuffer_scanout_sync_fifo #(
        .WIDTH (1),
        .DEPTH (2)
    ) u_tag_q (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (tag_push),
        .data_i  (read_addr[0]),
        .pop_i   (link_io.rx_valid),
        .data_o  (tag_head),
        .empty_o (tag_empty),
        .full_o  (tag_full),
        .count_o (tag_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WIdle: if (!wq_empty) state_d = WAddr;
            WAddr: if (write_take) state_d = WData;
            WData: begin
                if (write_take) begin
                    state_d = (wq_count > WQ_CNT_BITS'(1) || wq_push) ? WAddr : WIdle;
                end
            end
            default: state_d = WIdle;
        endcase
    end

    always_comb begin
        link_io.tx_valid  = 1'b0;
        link_io.tx_header = '0;
        link_io.tx_data   = '0;
        wq_pop            = 1'b0;
        if (read_slot) begin
            link_io.tx_valid  = 1'b1;
            link_io.tx_header = PIO_RAM_EMU_HEADER_SEND_READ_ADDR;
            link_io.tx_data   = read_addr;
        end else begin
            unique case (state_q)
                WAddr: begin
                    link_io.tx_valid  = 1'b1;
                    link_io.tx_header = PIO_RAM_EMU_HEADER_SEND_WRITE_ADDR;
                    link_io.tx_data   = wq_head[31:16];
                end
                WData: begin
                    link_io.tx_valid  = 1'b1;
                    link_io.tx_header = PIO_RAM_EMU_HEADER_SEND_WRITE_DATA;
                    link_io.tx_data   = wq_head[15:0];
                    wq_pop            = link_io.tx_accepted;
                end
                default: ;
            endcase
        end
    end

    assign field_idx = x_i[LOG2_CYCLES_PER_READ -: LOG2_PIXELS_PER_WORD+1];
    assign bit_lo    = 5'(field_idx) << (4 - LOG2_PIXELS_PER_WORD);

    always_comb begin
        buf_d = buf_q;
        if (link_io.rx_valid && !tag_empty) begin
            if (tag_head) buf_d[31:16] = link_io.rx_data;
            else          buf_d[15:0]  = link_io.rx_data;
        end
        err_d   = err_q | {link_io.rx_valid && tag_empty, read_slot && !link_io.tx_accepted};
        pixel_d = active_i ? buf_q[bit_lo +: PIXEL_BITS] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q   <= 1'b0;
            buf_q   <= '0;
            err_q   <= '0;
            pixel_q <= '0;
        end else begin
            run_q   <= 1'b1;
            buf_q   <= buf_d;
            err_q   <= err_d;
            pixel_q <= pixel_d;
        end
    end

    assign pixel_o     = pixel_q;
    assign err_flags_o = err_q;
    assign unused_bits = ^{y_i, early_x, tag_count, tag_full};

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed and randomized checks of framebuffer_scanout against a queue-based reference model.
module tb_framebuffer_scanout;
    import framebuffer_scanout_pkg::*;

    localparam int XB = 12, YB = 10, VYB = 9, LCPP = 2, LPPW = 3, RHS = 48, WQD = 4;
    localparam int LCPR = LCPP + LPPW;
    localparam int PB   = 16 >> LPPW;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic          active, wr_valid, wr_ready, wr_ready_b;
    logic [15:0]   wr_addr, wr_data;
    logic [PB-1:0] pixel;
    logic [3:0]    pixel_b;
    logic [1:0]    err, err_b;
    logic          wr_valid_b = 1'b0;

    framebuffer_scanout_if lnk ();
    framebuffer_scanout_if lnkb ();

    framebuffer_scanout dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x_i         (x),
        .y_i         (y),
        .active_i    (active),
        .wr_valid_i  (wr_valid),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_ready_o  (wr_ready),
        .link_io     (lnk),
        .pixel_o     (pixel),
        .err_flags_o (err)
    );

    framebuffer_scanout #(
        .LOG2_PIXELS_PER_WORD (2)
    ) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .x_i         (x),
        .y_i         (y),
        .active_i    (active),
        .wr_valid_i  (wr_valid_b),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_ready_o  (wr_ready_b),
        .link_io     (lnkb),
        .pixel_o     (pixel_b),
        .err_flags_o (err_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: message queue of pending writes, outstanding read tags, word buffer
    logic [19:0] msgs[$];
    logic        tags[$];
    logic [31:0] bufm;
    logic [1:0]  errm;
    logic        run_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd_addr_m(input logic [XB-1:0] ex, input logic [YB-1:0] yy);
        int word = ((int'(ex) >> LCPP) % (1 << (16 - VYB))) >> LPPW;
        int row  = int'(yy) % (1 << VYB);
        return 16'(row * (1 << (16 - VYB)) + word);
    endfunction

    function automatic logic [31:0] field_m(input logic [31:0] b, input logic [XB-1:0] xx);
        int i = (int'(xx) >> LCPP) % (1 << (LPPW + 1));
        return (b >> (i * PB)) & ((32'd1 << PB) - 32'd1);
    endfunction

    task automatic model_clear();
        msgs.delete();
        tags.delete();
        bufm  = '0;
        errm  = '0;
        run_m = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_tx_valid", lnk.tx_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_pixel", pixel, 0);
        chk("rst_wr_ready", wr_ready, 0);
        model_clear();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // One clock: combinational link outputs checked before the edge, registered ones after it
    task automatic cycle();
        logic [XB-1:0] ex, x_old;
        logic          rs, exp_rdy, push, wacc, act_old;
        logic [15:0]   ra;
        logic [31:0]   buf_old;
        @(negedge clk);
        ex      = x + XB'(RHS);
        rs      = run_m && ((int'(ex) % (1 << LCPR)) == 0);
        ra      = rd_addr_m(ex, y);
        exp_rdy = run_m && (((msgs.size() + 1) / 2) < WQD);
        chk("wr_ready", wr_ready, exp_rdy);
        if (rs) begin
            chk("rd_valid", lnk.tx_valid, 1);
            chk("rd_header", lnk.tx_header, PIO_RAM_EMU_HEADER_SEND_READ_ADDR);
            chk("rd_addr", lnk.tx_data, ra);
        end else if (msgs.size() == 0) begin
            chk("idle_valid", lnk.tx_valid, 0);
        end else if (lnk.tx_valid) begin
            chk("wr_header", lnk.tx_header, msgs[0][19:16]);
            chk("wr_payload", lnk.tx_data, msgs[0][15:0]);
        end
        push    = wr_valid && exp_rdy;
        wacc    = !rs && lnk.tx_valid && lnk.tx_accepted && (msgs.size() > 0);
        buf_old = bufm;
        x_old   = x;
        act_old = active;
        if (lnk.rx_valid) begin
            if (tags.size() == 0) begin
                errm[1] = 1'b1;
            end else begin
                if (tags[0]) bufm[31:16] = lnk.rx_data;
                else         bufm[15:0]  = lnk.rx_data;
                void'(tags.pop_front());
            end
        end
        if (rs) begin
            if (lnk.tx_accepted) begin
                if (tags.size() < 2) tags.push_back(ra[0]);
            end else begin
                errm[0] = 1'b1;
            end
        end
        if (wacc) void'(msgs.pop_front());
        if (push) begin
            msgs.push_back({PIO_RAM_EMU_HEADER_SEND_WRITE_ADDR, wr_addr});
            msgs.push_back({PIO_RAM_EMU_HEADER_SEND_WRITE_DATA, wr_data});
        end
        run_m = 1'b1;
        @(posedge clk);
        #1;
        chk("pixel", pixel, act_old ? field_m(buf_old, x_old) : 32'd0);
        chk("err_flags", err, errm);
    endtask

    initial begin
        x = '0; y = '0; active = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        lnk.tx_accepted = 1'b0; lnk.rx_valid = 1'b0; lnk.rx_data = '0;
        lnkb.tx_accepted = 1'b1; lnkb.rx_valid = 1'b0; lnkb.rx_data = '0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Read address at the start of a read period
        lnk.tx_accepted = 1'b1;
        y = 10'd5;
        x = 12'hFCF;
        cycle();
        x = 12'hFD0;
        cycle();

        // Fill the write queue while nothing is accepted, then drain it
        lnk.tx_accepted = 1'b0;
        x = 12'hFD1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 16'($urandom);
            wr_data  = 16'($urandom);
            cycle();
            x++;
        end
        wr_valid = 1'b0;
        chk("wq_full", wr_ready, 0);
        lnk.tx_accepted = 1'b1;
        for (int k = 0; k < 200 && msgs.size() != 0; k++) begin
            cycle();
            x++;
        end
        chk("wq_drain", msgs.size(), 0);

        // Reset while a write pair is half sent
        wr_valid = 1'b1;
        wr_addr  = 16'hBEEF;
        wr_data  = 16'hCAFE;
        cycle();
        x++;
        wr_valid = 1'b0;
        for (int k = 0; k < 50 && msgs.size() != 1; k++) begin
            cycle();
            x++;
        end
        chk("mid_wdata", msgs.size(), 1);
        do_reset();
        for (int k = 0; k < 40; k++) begin
            cycle();
            x++;
        end

        // Two returned words, then a pixel sweep
        active = 1'b1;
        for (int k = 0; k < 100 && tags.size() < 2; k++) begin
            cycle();
            x++;
        end
        chk("tags_ready", tags.size(), 2);
        lnk.rx_valid = 1'b1;
        lnk.rx_data  = 16'h1234;
        cycle();
        x++;
        lnk.rx_data  = 16'hABCD;
        cycle();
        x++;
        lnk.rx_valid = 1'b0;
        x = '0;
        for (int k = 0; k < 64; k++) begin
            cycle();
            x++;
        end

        // Dropped reads leave the outstanding tags untouched; a third return is an orphan
        lnk.tx_accepted = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            x++;
        end
        chk("err_drop", err, 2'b01);
        lnk.rx_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            lnk.rx_data = 16'($urandom);
            cycle();
            x++;
        end
        chk("tags_kept", err, 2'b01);
        lnk.rx_data = 16'hFFFF;
        cycle();
        x++;
        lnk.rx_valid = 1'b0;
        chk("err_orphan", err, 2'b11);
        for (int k = 0; k < 32; k++) begin
            cycle();
            x++;
        end

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            wr_valid        = ($urandom_range(1) == 0);
            wr_addr         = 16'($urandom);
            wr_data         = 16'($urandom);
            lnk.tx_accepted = ($urandom_range(4) != 0);
            lnk.rx_valid    = ($urandom_range(9) == 0);
            lnk.rx_data     = 16'($urandom);
            active          = ($urandom_range(9) < 7);
            cycle();
            if ($urandom_range(63) == 0) begin
                x = XB'($urandom);
                y = YB'($urandom);
            end else begin
                x++;
            end
        end

        // 4 bpp instance: one word in both buffer halves, then sweep
        wr_valid = 1'b0;
        lnk.rx_valid = 1'b0;
        lnk.tx_accepted = 1'b1;
        active = 1'b1;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            cycle();
            x++;
        end
        lnkb.rx_valid = 1'b1;
        lnkb.rx_data  = 16'h00F1;
        cycle();
        x++;
        cycle();
        x++;
        lnkb.rx_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            x = XB'(k);
            cycle();
            chk("b_pixel", pixel_b, (32'h00F100F1 >> (4 * ((k >> 2) % 8))) & 32'hF);
        end
        chk("b_err", err_b, 0);
        chk("b_wr_ready", wr_ready_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
